// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rggen_rtl_pkg
// Purpose : Shared types for the register-access bus: response status codes
//           returned by register blocks and the access direction encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'd0,
      RGGEN_EXOKAY       = 2'd1,
      RGGEN_SLAVE_ERROR  = 2'd2,
      RGGEN_DECODE_ERROR = 2'd3
   } rggen_status;

   typedef enum logic {
      RGGEN_READ  = 1'b0,
      RGGEN_WRITE = 1'b1
   } rggen_access;

endpackage
`default_nettype wire

// File: rtl/rggen_access_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rggen_access_timer
// Purpose : Watchdog for an outstanding register request. Counts enabled
//           cycles since the last clear and flags the final allowed cycle.
//           TIMEOUT_CYCLES = 0 removes the counter and never expires.
// Ports   : i_clk, i_rst     clock, asynchronous active-high reset
//           i_clear          restart the count at zero
//           i_enable         request outstanding this cycle
//           o_expired        this is the last cycle the request may wait
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module rggen_access_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         logic w_unused_inputs;
         assign w_unused_inputs = ^{i_clk, i_rst, i_clear, i_enable};
         assign o_expired       = 1'b0;
      end else begin : g_enabled
         localparam int c_COUNT_WIDTH =
            ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
         localparam logic [c_COUNT_WIDTH-1:0] c_ONE  = c_COUNT_WIDTH'(1);
         localparam logic [c_COUNT_WIDTH-1:0] c_MAX  = c_COUNT_WIDTH'(TIMEOUT_CYCLES);
         localparam logic [c_COUNT_WIDTH-1:0] c_LAST = c_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

         logic [c_COUNT_WIDTH-1:0] r_count;

         // Saturates at TIMEOUT_CYCLES so a long stall can never wrap back
         // into the expiry window.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_count <= '0;
            end else if (i_clear) begin
               r_count <= '0;
            end else if (i_enable && (r_count != c_MAX)) begin
               r_count <= r_count + c_ONE;
            end
         end

         assign o_expired = i_enable && (r_count == c_LAST);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/rggen_apb_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rggen_apb_bridge
// Purpose : APB4 slave that issues single-beat requests on the internal
//           register-access bus and returns a one-cycle APB completion.
//           A watchdog converts a stalled register access into SLVERR.
// Ports   : i_clk, i_rst                  clock, async active-high reset
//           i_psel..i_pwdata              APB4 request side (pprot ignored)
//           o_pready/o_pslverr/o_prdata   APB completion, valid one cycle
//           o_reg_*                       register request, held while valid
//           i_reg_ready/status/read_data  register response
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module rggen_apb_bridge
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_psel,
   input  logic                     i_penable,
   input  logic                     i_pwrite,
   input  logic [ADDRESS_WIDTH-1:0] i_paddr,
   input  logic [2:0]               i_pprot,
   input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
   input  logic [BUS_WIDTH-1:0]     i_pwdata,
   output logic                     o_pready,
   output logic                     o_pslverr,
   output logic [BUS_WIDTH-1:0]     o_prdata,
   output logic                     o_reg_valid,
   output logic                     o_reg_write,
   output logic [ADDRESS_WIDTH-1:0] o_reg_address,
   output logic [BUS_WIDTH-1:0]     o_reg_write_data,
   output logic [BUS_WIDTH-1:0]     o_reg_mask,
   input  logic                     i_reg_ready,
   input  logic [1:0]               i_reg_status,
   input  logic [BUS_WIDTH-1:0]     i_reg_read_data
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQUEST  = 2'd1,
      RESPONSE = 2'd2
   } state_e;

   localparam int c_ADDR_LSB = $clog2(BUS_WIDTH / 8);
   localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << c_ADDR_LSB;

   state_e                     r_state;
   logic                       r_reg_valid;
   logic                       r_reg_write;
   logic [ADDRESS_WIDTH-1:0]   r_reg_address;
   logic [BUS_WIDTH-1:0]       r_reg_write_data;
   logic [BUS_WIDTH-1:0]       r_reg_mask;
   logic                       r_pready;
   logic                       r_pslverr;
   logic [BUS_WIDTH-1:0]       r_prdata;

   state_e                     w_state_next;
   logic                       w_reg_valid_next;
   logic                       w_reg_write_next;
   logic [ADDRESS_WIDTH-1:0]   w_reg_address_next;
   logic [BUS_WIDTH-1:0]       w_reg_write_data_next;
   logic [BUS_WIDTH-1:0]       w_reg_mask_next;
   logic                       w_pready_next;
   logic                       w_pslverr_next;
   logic [BUS_WIDTH-1:0]       w_prdata_next;

   logic [BUS_WIDTH-1:0]       w_strb_mask;
   logic                       w_timer_clear;
   logic                       w_timer_expired;
   rggen_access                w_access;
   rggen_status                w_status;
   logic                       w_unused_pprot;

   assign w_access       = rggen_access'(i_pwrite);
   assign w_status       = rggen_status'(i_reg_status);
   assign w_unused_pprot = ^i_pprot;

   // Byte strobes fanned out to one mask bit per data bit.
   always_comb begin
      w_strb_mask = '0;
      for (int i = 0; i < BUS_WIDTH; i++) begin
         w_strb_mask[i] = i_pstrb[i/8];
      end
   end

   rggen_access_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_access_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_timer_clear),
      .i_enable  (r_state == REQUEST),
      .o_expired (w_timer_expired)
   );

   // Next-state and next-output logic. Every output is computed one cycle
   // ahead and registered, so the APB response leaves from flops.
   always_comb begin
      w_state_next          = r_state;
      w_reg_valid_next      = 1'b0;
      w_reg_write_next      = r_reg_write;
      w_reg_address_next    = r_reg_address;
      w_reg_write_data_next = r_reg_write_data;
      w_reg_mask_next       = r_reg_mask;
      w_pready_next         = 1'b0;
      w_pslverr_next        = 1'b0;
      w_prdata_next         = '0;
      w_timer_clear         = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_psel && !i_penable) begin
               w_state_next          = REQUEST;
               w_reg_valid_next      = 1'b1;
               w_reg_write_next      = (w_access == RGGEN_WRITE);
               w_reg_address_next    = i_paddr & c_ADDR_MASK;
               w_reg_write_data_next = i_pwdata;
               w_reg_mask_next       = (w_access == RGGEN_WRITE) ? w_strb_mask : '1;
               w_timer_clear         = 1'b1;
            end
         end
         REQUEST: begin
            if (i_reg_ready) begin
               w_state_next   = RESPONSE;
               w_pready_next  = 1'b1;
               w_pslverr_next = (w_status == RGGEN_SLAVE_ERROR) ||
                                (w_status == RGGEN_DECODE_ERROR);
               w_prdata_next  = r_reg_write ? '0 : i_reg_read_data;
            end else if (w_timer_expired) begin
               w_state_next   = RESPONSE;
               w_pready_next  = 1'b1;
               w_pslverr_next = 1'b1;
            end else begin
               w_reg_valid_next = 1'b1;
            end
         end
         RESPONSE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state          <= IDLE;
         r_reg_valid      <= 1'b0;
         r_reg_write      <= 1'b0;
         r_reg_address    <= '0;
         r_reg_write_data <= '0;
         r_reg_mask       <= '0;
         r_pready         <= 1'b0;
         r_pslverr        <= 1'b0;
         r_prdata         <= '0;
      end else begin
         r_state          <= w_state_next;
         r_reg_valid      <= w_reg_valid_next;
         r_reg_write      <= w_reg_write_next;
         r_reg_address    <= w_reg_address_next;
         r_reg_write_data <= w_reg_write_data_next;
         r_reg_mask       <= w_reg_mask_next;
         r_pready         <= w_pready_next;
         r_pslverr        <= w_pslverr_next;
         r_prdata         <= w_prdata_next;
      end
   end

   assign o_pready         = r_pready;
   assign o_pslverr        = r_pslverr;
   assign o_prdata         = r_prdata;
   assign o_reg_valid      = r_reg_valid;
   assign o_reg_write      = r_reg_write;
   assign o_reg_address    = r_reg_address;
   assign o_reg_write_data = r_reg_write_data;
   assign o_reg_mask       = r_reg_mask;

endmodule
`default_nettype wire

// File: tb/tb_rggen_apb_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_rggen_apb_bridge
// Purpose : Directed bench for rggen_apb_bridge. Each transfer pushes its
//           expected response into a scoreboard queue; the entry is popped
//           and compared when o_pready is seen.
// Ports   : none
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_rggen_apb_bridge;

   logic        clk;
   logic        rst;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;
   logic        reg_valid;
   logic        reg_write;
   logic [7:0]  reg_address;
   logic [31:0] reg_write_data;
   logic [31:0] reg_mask;
   logic        reg_ready;
   logic [1:0]  reg_status;
   logic [31:0] reg_read_data;

   rggen_apb_bridge #(
      .ADDRESS_WIDTH  (8),
      .BUS_WIDTH      (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_psel           (psel),
      .i_penable        (penable),
      .i_pwrite         (pwrite),
      .i_paddr          (paddr),
      .i_pprot          (pprot),
      .i_pstrb          (pstrb),
      .i_pwdata         (pwdata),
      .o_pready         (pready),
      .o_pslverr        (pslverr),
      .o_prdata         (prdata),
      .o_reg_valid      (reg_valid),
      .o_reg_write      (reg_write),
      .o_reg_address    (reg_address),
      .o_reg_write_data (reg_write_data),
      .o_reg_mask       (reg_mask),
      .i_reg_ready      (reg_ready),
      .i_reg_status     (reg_status),
      .i_reg_read_data  (reg_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        write;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] mask;
      int          done_cycle;
      int          valid_cycles;
      logic        slverr;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pready"},    {31'd0, pready},    32'd0);
      check({tag, ".pslverr"},   {31'd0, pslverr},   32'd0);
      check({tag, ".prdata"},    prdata,             32'd0);
      check({tag, ".reg_valid"}, {31'd0, reg_valid}, 32'd0);
      check({tag, ".reg_write"}, {31'd0, reg_write}, 32'd0);
      check({tag, ".reg_addr"},  {24'd0, reg_address}, 32'd0);
      check({tag, ".reg_wdata"}, reg_write_data,     32'd0);
      check({tag, ".reg_mask"},  reg_mask,           32'd0);
   endtask

   // One APB transfer. k = cycle after setup on which i_reg_ready is raised;
   // k < 0 never raises it, exercising the 16-cycle watchdog.
   task automatic xfer(input string tag, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input int k,
                       input logic [1:0] status, input logic [31:0] rdata);
      exp_t e;
      exp_t got;
      int   valid_cnt = 0;
      int   done_at   = 0;
      e.tag          = tag;
      e.write        = wr;
      e.addr         = addr & 8'hFC;
      e.wdata        = wdata;
      e.mask         = 32'hFFFF_FFFF;
      if (wr) begin
         for (int b = 0; b < 4; b++) e.mask[b*8 +: 8] = {8{strb[b]}};
      end
      e.done_cycle   = (k < 0) ? 17 : k + 1;
      e.valid_cycles = (k < 0) ? 16 : k;
      e.slverr       = (k < 0) ? 1'b1 : status[1];
      e.rdata        = (k < 0 || wr) ? 32'd0 : rdata;
      sb.push_back(e);

      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
      pwdata = wdata; pstrb = strb; reg_ready = 1'b0;
      reg_status = status; reg_read_data = rdata;
      step();
      penable = 1'b1;
      for (int c = 1; c <= 40 && done_at == 0; c++) begin
         if (pready) begin
            done_at = c;
         end else begin
            if (reg_valid) valid_cnt++;
            check({tag, ".valid"},     {31'd0, reg_valid}, 32'd1);
            check({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, e.write});
            check({tag, ".reg_addr"},  {24'd0, reg_address}, {24'd0, e.addr});
            check({tag, ".reg_wdata"}, reg_write_data, e.wdata);
            check({tag, ".reg_mask"},  reg_mask, e.mask);
            reg_ready = (c == k);
            step();
         end
      end
      reg_ready = 1'b0;
      if (done_at == 0) begin
         check({tag, ".pready_timeout"}, 32'd0, 32'd1);
      end
      if (sb.size() == 0) begin
         check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         check({got.tag, ".done_cycle"},   done_at,   got.done_cycle);
         check({got.tag, ".valid_cycles"}, valid_cnt, got.valid_cycles);
         check({got.tag, ".pslverr"},      {31'd0, pslverr}, {31'd0, got.slverr});
         check({got.tag, ".prdata"},       prdata,    got.rdata);
      end
      // Master samples pready on this edge; completion must last one cycle.
      step();
      check({tag, ".pready_one_cycle"}, {31'd0, pready}, 32'd0);
      check({tag, ".prdata_cleared"},   prdata, 32'd0);
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pprot = 3'b000; pstrb = '0; pwdata = '0;
      reg_ready = 1'b0; reg_status = 2'd0; reg_read_data = '0;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // Ready outside a request must be ignored.
      reg_ready = 1'b1;
      step();
      step();
      reg_ready = 1'b0;
      check("stray_ready.pready", {31'd0, pready},    32'd0);
      check("stray_ready.valid",  {31'd0, reg_valid}, 32'd0);

      xfer("wr_strb5",  1'b1, 8'h10, 32'hA5A5_1234, 4'b0101,  2, 2'd0, 32'hCAFE_F00D);
      step();
      xfer("rd_okay",   1'b0, 8'h04, 32'h0000_0000, 4'b0000,  1, 2'd0, 32'hDEAD_BEEF);
      step();
      xfer("rd_decerr", 1'b0, 8'h08, 32'h0000_0000, 4'b0000,  1, 2'd3, 32'h1234_5678);
      step();
      xfer("wr_slverr", 1'b1, 8'h0C, 32'h0BAD_0BAD, 4'b1111,  3, 2'd2, 32'h0);
      step();
      xfer("rd_timeout",1'b0, 8'h30, 32'h0000_0000, 4'b0000, -1, 2'd0, 32'hFFFF_FFFF);

      // Back-to-back writes, second with no strobes and an unaligned address.
      xfer("b2b_a",     1'b1, 8'h20, 32'h1111_2222, 4'b1111,  1, 2'd0, 32'h0);
      xfer("b2b_b",     1'b1, 8'h27, 32'h3333_4444, 4'b0000,  2, 2'd1, 32'h0);
      step();

      // Reset while a request is outstanding.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h40;
      pwdata = 32'h5555_AAAA; pstrb = 4'b1111;
      step();
      penable = 1'b1;
      check("pre_reset.valid", {31'd0, reg_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      #1;
      psel = 1'b0; penable = 1'b0;
      rst = 1'b0;
      step();
      check("post_reset.idle", {31'd0, reg_valid}, 32'd0);
      xfer("rd_after_rst", 1'b0, 8'h44, 32'h0, 4'b0000, 2, 2'd0, 32'h8765_4321);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
